// File: rtl/div_32bit_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, MSB first. The dividend register doubles as
// the quotient accumulator: each iteration shifts a dividend bit out of the
// top and a quotient bit in at the bottom. Signed operations run on
// magnitudes and fix the result signs in a final cycle. Divide-by-zero and
// the signed-overflow case bypass the iteration and finish immediately.
module div_32bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             dbz_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    // Two's complement negation, modulo 2^WIDTH (the most negative value maps to itself).
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    // Shift the next dividend bit into the partial remainder. The shifted value
    // needs WIDTH+1 bits: with a divisor above 2^(WIDTH-1) the remainder's top
    // bit can be set before the shift, and dropping it would corrupt the compare.
    logic [WIDTH:0]   rem_shift;
    logic             q_bit;
    logic [WIDTH-1:0] rem_sub;

    // One restoring iteration: subtract when the shifted remainder covers the divisor.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        // When q_bit is set the true difference is below 2^WIDTH, so the low bits suffice.
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path leaves
        // one unassigned; an unassigned path in a combinational block infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    neg_quo_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    neg_rem_d = signed_i & dividend_i[WIDTH-1];
                    dvd_d     = signed_i ? magnitude(dividend_i) : dividend_i;
                    dvs_d     = signed_i ? magnitude(divisor_i)  : divisor_i;
                    rem_d     = '0;
                    cnt_d     = CNT_LAST;
                    if (divisor_i == '0) begin
                        quo_out_d = '1;
                        rem_out_d = dividend_i;
                        dbz_d     = 1'b1;
                        state_d   = S_DONE;
                    end else if (signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1)) begin
                        quo_out_d = MIN_NEG;
                        rem_out_d = '0;
                        dbz_d     = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                quo_out_d = neg_quo_q ? negate(dvd_q) : dvd_q;
                rem_out_d = neg_rem_q ? negate(rem_q) : rem_q;
                dbz_d     = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any operation in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values,
        // so the order of these statements does not matter.
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy_o      = (state_q == S_CALC) || (state_q == S_FIX);
    assign valid_o     = (state_q == S_DONE);
    assign quotient_o  = quo_out_q;
    assign remainder_o = rem_out_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Testbench for div_32bit_seq: table of directed vectors plus hand-written
// sequences for mid-operation reset and back-to-back requests.
// Inputs change and outputs are sampled on the falling clock edge.
// Latency is counted in rising edges after the accept edge: the iterative path
// shows valid_o after edge 33; the fast paths show it right after the accept edge.
module tb_div_32bit_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        dbz_o;

    int checks = 0;
    int errors = 0;

    div_32bit_seq #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .dbz_o       (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one request with a single-cycle start pulse and check its result.
    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        bit seen;
        bit busy_bad;
        cyc      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        @(negedge clk_i);
        start_i    = 1'b1;
        signed_i   = v.sgn;
        dividend_i = v.dvd;
        divisor_i  = v.dvs;
        @(posedge clk_i);   // accept edge
        while (!seen && cyc <= 40) begin
            @(negedge clk_i);
            if (cyc == 0) begin
                // Scramble operands right after accept; the result must not move.
                start_i    = 1'b0;
                signed_i   = ~v.sgn;
                dividend_i = ~v.dvd;
                divisor_i  = v.dvs + 32'd5;
            end
            if (valid_o) begin
                seen = 1'b1;
            end else begin
                if (!busy_o) busy_bad = 1'b1;
                cyc++;
            end
        end
        check({tag, " valid seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(v.lat));
        check({tag, " quotient"}, quotient_o, v.q);
        check({tag, " remainder"}, remainder_o, v.r);
        check({tag, " dbz"}, 32'(dbz_o), 32'(v.dbz));
        check({tag, " busy while waiting"}, 32'(busy_bad), 32'd0);
        check({tag, " busy low in DONE"}, 32'(busy_o), 32'd0);
        @(negedge clk_i);
        check({tag, " valid one cycle"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        int nvalid;
        int busy_low;
        vec_t v;

        // sgn  dividend       divisor        quotient       remainder     dbz lat
        vecs[0]  = '{1'b0, 32'd100,        32'd7,         32'd14,        32'd2,        1'b0, 33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 33};
        vecs[3]  = '{1'b1, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0};
        vecs[4]  = '{1'b0, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 0};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0, 33};
        vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 33};
        vecs[9]  = '{1'b0, 32'd7,          32'd7,         32'd1,         32'd0,        1'b0, 33};
        vecs[10] = '{1'b0, 32'd3,          32'd5,         32'd0,         32'd3,        1'b0, 33};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd2,         32'hC000_0000, 32'd0,        1'b0, 33};
        vecs[12] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32'd0,        1'b0, 33};
        vecs[13] = '{1'b0, 32'hDEAD_BEEF,  32'd16,        32'h0DEA_DBEE, 32'hF,        1'b0, 33};

        rst_i      = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset quotient", quotient_o, 32'd0);
        check("reset remainder", remainder_o, 32'd0);
        check("reset dbz", 32'(dbz_o), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an unsigned divide discards the operation.
        @(negedge clk_i);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midreset busy", 32'(busy_o), 32'd0);
        check("midreset valid", 32'(valid_o), 32'd0);
        check("midreset quotient", quotient_o, 32'd0);
        check("midreset remainder", remainder_o, 32'd0);
        check("midreset dbz", 32'(dbz_o), 32'd0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) nvalid++;
        end
        check("midreset no stale valid", 32'(nvalid), 32'd0);
        v = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
        run_op(v, "after reset");

        // Back-to-back: start held high, operands changed mid-operation.
        // A = 1000/3 unsigned accepted first; B = -100/7 signed is accepted two
        // edges after A's DONE; C (5/0) arrives during B and must be ignored.
        @(negedge clk_i);
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        @(posedge clk_i);   // accept edge of A
        nvalid   = 0;
        busy_low = 0;
        for (int cyc = 0; cyc <= 70; cyc++) begin
            @(negedge clk_i);
            if (cyc == 0) begin
                signed_i   = 1'b1;
                dividend_i = 32'hFFFF_FF9C;
                divisor_i  = 32'd7;
            end
            if (cyc == 40) begin
                signed_i   = 1'b0;
                dividend_i = 32'd5;
                divisor_i  = 32'd0;
            end
            if (cyc == 68) start_i = 1'b0;
            if (cyc < 68 && !busy_o) busy_low++;
            if (valid_o) begin
                nvalid++;
                if (cyc == 33) begin
                    check("b2b A quotient", quotient_o, 32'd333);
                    check("b2b A remainder", remainder_o, 32'd1);
                end else if (cyc == 68) begin
                    check("b2b B quotient", quotient_o, 32'hFFFF_FFF2);
                    check("b2b B remainder", remainder_o, 32'hFFFF_FFFE);
                    check("b2b B dbz", 32'(dbz_o), 32'd0);
                end else begin
                    check("b2b valid at unexpected cycle", 32'(cyc), 32'd0);
                end
            end
        end
        check("b2b valid count", 32'(nvalid), 32'd2);
        check("b2b busy low cycles", 32'(busy_low), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
